// File: rtl/loop_launcher.sv
// loop_launcher: launches one run of a downstream loop core, steers its
//    per-cycle branch input and reports the outcome (done or timeout).
//    Latency: start handshake -> 1 LAUNCH cycle -> RUN cycles 1..MAX_CYCLES -> REPORT.
//    Backpressure: start_ready only in IDLE; REPORT holds result until res_ready.
// Ports:
//    clk, rst                      clock, async active-high reset
//    start_valid/start_ready       run request handshake, seed + branch_mode captured
//    core_rst/core_x_raw/core_branch  drive the loop core
//    core_done/core_lock           loop core status
//    res_valid/res_ready           result handshake, res_lock/res_cycles/res_timeout
module loop_launcher #(
   parameter int          WIDTH      = 32,
   parameter int          MAX_CYCLES = 64,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] seed,
   input  logic [1:0]       branch_mode,
   output logic             core_rst,
   output logic [WIDTH-1:0] core_x_raw,
   output logic             core_branch,
   input  logic             core_done,
   input  logic             core_lock,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_lock,
   output logic [15:0]      res_cycles,
   output logic             res_timeout
);

   // An all-zero seed would lock the LFSR up, so fall back to the default.
   localparam logic [15:0] LFSR_INIT = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
   localparam logic [15:0] MAX_CNT   = 16'(MAX_CYCLES);

   typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_RUN, ST_REPORT} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   seed_q;
   logic [1:0]         mode_q;
   logic [15:0]        cnt_q;
   logic [15:0]        lfsr_q;
   logic               res_lock_q;
   logic [15:0]        res_cycles_q;
   logic               res_timeout_q;

   // cnt_q counts completed RUN cycles, so the current RUN cycle number is cnt_q+1.
   logic [15:0] run_k;
   logic        last_cycle;
   logic        lfsr_fb;

   assign run_k      = cnt_q + 16'd1;
   assign last_cycle = (run_k == MAX_CNT);
   // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1.
   assign lfsr_fb    = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (start_valid) state_d = ST_LAUNCH;
         ST_LAUNCH: state_d = ST_RUN;
         ST_RUN:    if (core_done || last_cycle) state_d = ST_REPORT;
         ST_REPORT: if (res_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seed_q        <= '0;
         mode_q        <= 2'b00;
         cnt_q         <= 16'd0;
         lfsr_q        <= LFSR_INIT;
         res_lock_q    <= 1'b0;
         res_cycles_q  <= 16'd0;
         res_timeout_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_valid) begin
                  seed_q <= seed;
                  mode_q <= branch_mode;
               end
            end
            ST_LAUNCH: begin
               cnt_q  <= 16'd0;
               lfsr_q <= LFSR_INIT;
            end
            ST_RUN: begin
               cnt_q  <= run_k;
               lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
               // Done wins over budget exhaustion in the final cycle.
               if (core_done || last_cycle) begin
                  res_lock_q    <= core_lock;
                  res_cycles_q  <= run_k;
                  res_timeout_q <= ~core_done;
               end
            end
            default: ;
         endcase
      end
   end

   // Output logic
   always_comb begin
      start_ready = (state_q == ST_IDLE);
      core_rst    = (state_q != ST_RUN);
      res_valid   = (state_q == ST_REPORT);
      core_branch = 1'b0;
      if (state_q == ST_RUN) begin
         unique case (mode_q)
            2'b00:   core_branch = 1'b0;
            2'b01:   core_branch = 1'b1;
            default: core_branch = lfsr_q[0];
         endcase
      end
   end

   assign core_x_raw  = seed_q;
   assign res_lock    = res_lock_q;
   assign res_cycles  = res_cycles_q;
   assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_loop_launcher.sv
// tb_loop_launcher: randomized self-checking bench for loop_launcher.
//    Inputs driven and outputs checked on the falling clock edge.
//    A cycle-level model of the run timeline supplies every expected value.
module tb_loop_launcher;

   localparam int WIDTH = 32;
   localparam int MAXC  = 64;
   localparam int NEVER = 100000;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start_valid = 1'b0;
   logic             start_ready;
   logic [WIDTH-1:0] seed = '0;
   logic [1:0]       branch_mode = 2'b00;
   logic             core_rst;
   logic [WIDTH-1:0] core_x_raw;
   logic             core_branch;
   logic             core_done = 1'b0;
   logic             core_lock = 1'b0;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic             res_lock;
   logic [15:0]      res_cycles;
   logic             res_timeout;

   int vectors = 0;
   int miscompares = 0;

   loop_launcher #(
      .WIDTH(WIDTH),
      .MAX_CYCLES(MAXC),
      .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk), .rst(rst),
      .start_valid(start_valid), .start_ready(start_ready),
      .seed(seed), .branch_mode(branch_mode),
      .core_rst(core_rst), .core_x_raw(core_x_raw), .core_branch(core_branch),
      .core_done(core_done), .core_lock(core_lock),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_lock(res_lock), .res_cycles(res_cycles), .res_timeout(res_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference LFSR: x^16+x^14+x^13+x^11+1, bit 0 is the branch output.
   function automatic int lfsr_next(input int v);
      int fb;
      fb = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
      return ((v >> 1) | (fb << 15)) & 16'hFFFF;
   endfunction

   // One complete run. Entered and left at a falling edge with the DUT in IDLE.
   // done_at: RUN cycle in which core_done is raised (NEVER for none).
   // lock_sel: 0/1 fixed core_lock, 2 random per cycle.
   // hold: REPORT cycles with res_ready low before the handshake.
   // rst_at: RUN cycle in which rst is pulsed (0 for none).
   task automatic do_run(input logic [31:0] s, input logic [1:0] m, input int done_at,
                         input int lock_sel, input int hold, input int rst_at);
      int          lf;
      int          k;
      int          exp_cyc;
      logic        exp_to;
      logic        exp_lock;
      logic        lk;
      logic        exp_br;
      lf = 16'hACE1;
      exp_cyc = 0; exp_to = 1'b0; exp_lock = 1'b0;

      chk("idle_ready", start_ready, 1);
      chk("idle_core_rst", core_rst, 1);
      start_valid = 1'b1; seed = s; branch_mode = m;

      @(negedge clk);  // LAUNCH
      start_valid = 1'($urandom_range(0, 1));
      seed = $urandom; branch_mode = 2'($urandom_range(0, 3));
      chk("launch_core_rst", core_rst, 1);
      chk("launch_ready", start_ready, 0);
      chk("launch_x", core_x_raw, s);

      k = 0;
      forever begin
         @(negedge clk);  // RUN cycle k
         k++;
         exp_br = (m == 2'b00) ? 1'b0 : (m == 2'b01) ? 1'b1 : 1'(lf & 1);
         chk("run_core_rst", core_rst, 0);
         chk("run_ready", start_ready, 0);
         chk("run_x", core_x_raw, s);
         chk($sformatf("run_branch_k%0d", k), core_branch, exp_br);
         if (k == rst_at) begin
            #2 rst = 1'b1;
            #1;
            chk("arst_core_rst", core_rst, 1);
            chk("arst_res_valid", res_valid, 0);
            chk("arst_ready", start_ready, 1);
            chk("arst_branch", core_branch, 0);
            chk("arst_x", core_x_raw, 0);
            chk("arst_cycles", res_cycles, 0);
            start_valid = 1'b0; core_done = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("post_rst_no_result", res_valid, 0);
               chk("post_rst_idle", start_ready, 1);
            end
            return;
         end
         lk = (lock_sel == 2) ? 1'($urandom_range(0, 1)) : 1'(lock_sel);
         core_lock = lk;
         core_done = (k == done_at);
         start_valid = 1'($urandom_range(0, 1));
         lf = lfsr_next(lf);
         if (k == done_at) begin
            exp_cyc = k; exp_to = 1'b0; exp_lock = lk;
            break;
         end else if (k == MAXC) begin
            exp_cyc = MAXC; exp_to = 1'b1; exp_lock = lk;
            break;
         end
      end

      @(negedge clk);  // REPORT
      core_done = 1'b0;
      core_lock = 1'($urandom_range(0, 1));
      for (int i = 0; i <= hold; i++) begin
         chk("rep_valid", res_valid, 1);
         chk("rep_lock", res_lock, exp_lock);
         chk("rep_cycles", res_cycles, exp_cyc);
         chk("rep_timeout", res_timeout, exp_to);
         chk("rep_core_rst", core_rst, 1);
         chk("rep_ready", start_ready, 0);
         if (i == hold) begin
            res_ready = 1'b1; start_valid = 1'b1;
         end else begin
            res_ready = 1'b0; start_valid = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
      end
      chk("post_hs_valid", res_valid, 0);
      chk("post_hs_idle", start_ready, 1);
      chk("post_hs_core_rst", core_rst, 1);
      res_ready = 1'b0; start_valid = 1'b0;
   endtask

   initial begin
      #3;
      chk("reset_ready", start_ready, 1);
      chk("reset_core_rst", core_rst, 1);
      chk("reset_valid", res_valid, 0);
      chk("reset_lock", res_lock, 0);
      chk("reset_cycles", res_cycles, 0);
      chk("reset_timeout", res_timeout, 0);
      chk("reset_branch", core_branch, 0);
      chk("reset_x", core_x_raw, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      do_run(32'd5, 2'b01, 3, 1, 0, 0);            // done in cycle 3, locked
      do_run(32'h1234, 2'b00, NEVER, 0, 0, 0);     // timeout
      do_run(32'hCAFE, 2'b01, MAXC, 2, 0, 0);      // done on last budget cycle
      do_run(32'h77, 2'b10, 9, 2, 10, 0);          // REPORT held 10 cycles
      do_run(32'h99, 2'b01, NEVER, 2, 0, 7);       // reset mid-RUN
      do_run(32'hABCD, 2'b10, 20, 2, 1, 0);        // normal run after reset
      do_run(32'h1, 2'b10, NEVER, 2, 0, 0);        // LFSR sequence, full length
      do_run(32'h2, 2'b10, NEVER, 2, 0, 0);        // same sequence again
      do_run(32'h3, 2'b11, 30, 2, 0, 0);           // mode 11 behaves as 10
      do_run(32'h4, 2'b01, 1, 1, 0, 0);            // done in first cycle

      for (int r = 0; r < 30; r++) begin
         do_run($urandom, 2'($urandom_range(0, 3)), $urandom_range(1, MAXC + 16),
                2, $urandom_range(0, 5), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
